bram_lsu_ctrl: RTL and testbench

// - Load/store sequencer in front of the byte-wide single-port BRAM (async read, sync write).
// - Takes 32-bit byte/half/word requests from the LSU over a valid/ready handshake.
// - Issues one BRAM byte access per cycle, little-endian.
// - Returns a sign/zero-extended load result, or a store ack, on a valid/ready response channel.

---
 rtl/bram_ctrl_pkg.sv | 19 +
 rtl/bram_ld_ext.sv | 22 ++
 rtl/bram_lsu_ctrl.sv | 121 ++++++++++++
 tb/tb_bram_lsu_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_ctrl_pkg.sv
// Shared types and helpers for the byte-serial BRAM load/store controller.
// The size encoding matches the LSU request bus directly.
package bram_ctrl_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_ILL} size_e;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  function automatic logic [2:0] nbytes(size_e size);
    case (size)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      SZ_W:    return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/bram_ld_ext.sv
// Load-result extender: picks the low byte/half/word of the assembled bytes
// and sign- or zero-extends it to XLEN.
module bram_ld_ext
  import bram_ctrl_pkg::*;
(
  input  logic [XLEN-1:0] raw,
  input  size_e           size,
  input  logic            zero_ext,
  output logic [XLEN-1:0] rdata
);

  always_comb begin
    rdata = '0;
    case (size)
      SZ_B:    rdata = zero_ext ? {24'd0, raw[7:0]}   : {{24{raw[7]}}, raw[7:0]};
      SZ_H:    rdata = zero_ext ? {16'd0, raw[15:0]}  : {{16{raw[15]}}, raw[15:0]};
      SZ_W:    rdata = raw;
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/bram_lsu_ctrl.sv
// Load/store sequencer in front of a byte-wide single-port BRAM: one byte
// access per cycle, little-endian, with a held valid/ready response.
module bram_lsu_ctrl #(
  parameter int ADDR_WIDTH = 9,
  parameter int XLEN       = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [1:0]            i_req_size,
  input  logic                  i_req_unsigned,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [XLEN-1:0]       i_req_wdata,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [XLEN-1:0]       o_rsp_rdata,
  output logic                  o_rsp_err,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [7:0]            o_mem_wdata,
  input  logic [7:0]            i_mem_rdata
);
  import bram_ctrl_pkg::*;

  state_e                state_reg, state_next;
  size_e                 size_reg;
  size_e                 req_size;
  logic                  we_reg, uns_reg, err_reg;
  logic [ADDR_WIDTH-1:0] base_reg;
  logic [XLEN-1:0]       wdata_reg, asm_reg, ext_rdata;
  logic [1:0]            cnt_reg;
  logic [7:0]            wdata_byte [4];
  logic [3:0]            lane_cap;
  logic                  req_fire, req_err, last_byte, in_access, in_resp;

  assign req_size    = size_e'(i_req_size);
  assign o_req_ready = (state_reg == IDLE);
  assign req_fire    = i_req_valid && o_req_ready;
  assign in_access   = (state_reg == ACCESS);
  assign in_resp     = (state_reg == RESP);

  assign req_err = (req_size == SZ_ILL)
                || ((req_size == SZ_H) && i_req_addr[0])
                || ((req_size == SZ_W) && (i_req_addr[1:0] != 2'b00));

  assign last_byte = (({1'b0, cnt_reg} + 3'd1) == nbytes(size_reg));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req_fire) state_next = req_err ? RESP : ACCESS;
      ACCESS:  if (last_byte) state_next = RESP;
      RESP:    if (i_rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 2'd0;
      we_reg    <= 1'b0;
      size_reg  <= SZ_B;
      uns_reg   <= 1'b0;
      err_reg   <= 1'b0;
      base_reg  <= '0;
      wdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (req_fire) begin
        we_reg    <= i_req_we;
        size_reg  <= req_size;
        uns_reg   <= i_req_unsigned;
        err_reg   <= req_err;
        base_reg  <= i_req_addr;
        wdata_reg <= i_req_wdata;
        cnt_reg   <= 2'd0;
      end else if (in_access) begin
        cnt_reg <= cnt_reg + 2'd1;
      end
    end
  end

  // Per-lane store byte select and load capture strobe.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign wdata_byte[gi] = wdata_reg[gi*8 +: 8];
      assign lane_cap[gi]   = in_access && !we_reg && (cnt_reg == 2'(gi));
    end
  endgenerate

  // Cleared on accept so a short load never exposes bytes of an older one.
  always_ff @(posedge i_clk) begin
    if (i_reset || req_fire) begin
      asm_reg <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (lane_cap[i]) asm_reg[i*8 +: 8] <= i_mem_rdata;
      end
    end
  end

  bram_ld_ext u_ext (
    .raw      (asm_reg),
    .size     (size_reg),
    .zero_ext (uns_reg),
    .rdata    (ext_rdata)
  );

  assign o_mem_we    = in_access && we_reg;
  assign o_mem_addr  = in_access ? (base_reg + ADDR_WIDTH'(cnt_reg)) : '0;
  assign o_mem_wdata = in_access ? wdata_byte[cnt_reg] : 8'd0;

  assign o_rsp_valid = in_resp;
  assign o_rsp_err   = in_resp && err_reg;
  assign o_rsp_rdata = (in_resp && !err_reg && !we_reg) ? ext_rdata : '0;

endmodule

// File: tb/tb_bram_lsu_ctrl.sv
// Bench for bram_lsu_ctrl: a byte BRAM model, a transaction-level reference
// memory checked every cycle, directed scenarios and random traffic.
module tb_bram_lsu_ctrl;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0, req_we = 1'b0, req_uns = 1'b0, rsp_ready = 1'b0;
  logic [1:0]    req_size = 2'd0;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          o_req_ready, o_rsp_valid, o_rsp_err, o_mem_we;
  logic [31:0]   o_rsp_rdata;
  logic [AW-1:0] o_mem_addr;
  logic [7:0]    o_mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  bram_lsu_ctrl #(.ADDR_WIDTH(AW), .XLEN(32)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_req_valid(req_valid), .o_req_ready(o_req_ready), .i_req_we(req_we),
    .i_req_size(req_size), .i_req_unsigned(req_uns), .i_req_addr(req_addr),
    .i_req_wdata(req_wdata), .o_rsp_valid(o_rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err), .o_mem_we(o_mem_we),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .i_mem_rdata(mem_rdata)
  );

  // Byte BRAM: async read, sync write, deterministic power-up pattern.
  logic [7:0] mem [512];
  bit         mem_init_done = 1'b0;
  assign mem_rdata = mem[o_mem_addr];
  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 512; i++) mem[i] <= 8'(i * 37 + 5);
      mem_init_done <= 1'b1;
    end else if (o_mem_we) begin
      mem[o_mem_addr] <= o_mem_wdata;
    end
  end

  int n_cmp = 0, n_err = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state (transaction level).
  logic [7:0]  ref_mem [512];
  bit          busy = 1'b0, model_ready = 1'b0;
  int          age, m_n, cyc = 0, we_pulses = 0;
  logic        m_we, m_err;
  logic [8:0]  m_addr;
  logic [31:0] m_wdata, m_rdata;
  int          acc_q[$], hs_q[$];

  function automatic logic [31:0] load_val(input logic [8:0] a, input logic [1:0] sz, input logic uns);
    logic [31:0] v;
    case (sz)
      2'd0: begin
        v = {24'd0, ref_mem[a]};
        if (!uns && v[7]) v = v | 32'hFFFF_FF00;
      end
      2'd1: begin
        v = {16'd0, ref_mem[9'(a + 1)], ref_mem[a]};
        if (!uns && v[15]) v = v | 32'hFFFF_0000;
      end
      default: v = {ref_mem[9'(a + 3)], ref_mem[9'(a + 2)], ref_mem[9'(a + 1)], ref_mem[a]};
    endcase
    return v;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle compare against the model, sampled on the falling edge.
  always @(negedge clk) begin
    logic [8:0] ea;
    int k;
    if (o_mem_we === 1'b1) we_pulses++;
    if (!model_ready) begin
      for (int i = 0; i < 512; i++) ref_mem[i] = 8'(i * 37 + 5);
    end else if (!busy) begin
      chk("idle_req_ready", o_req_ready, 1);
      chk("idle_rsp_valid", o_rsp_valid, 0);
      chk("idle_mem_we", o_mem_we, 0);
      if (req_valid && !rst) begin
        m_we    = req_we;
        m_addr  = req_addr;
        m_wdata = req_wdata;
        m_err   = (req_size == 2'd3) || (req_size == 2'd1 && req_addr[0])
               || (req_size == 2'd2 && req_addr[1:0] != 2'd0);
        m_n     = m_err ? 0 : (1 << req_size);
        m_rdata = (m_err || m_we) ? 32'd0 : load_val(req_addr, req_size, req_uns);
        busy    = 1'b1;
        age     = 0;
        acc_q.push_back(cyc);
      end
    end else begin
      age++;
      chk("busy_req_ready", o_req_ready, 0);
      if (age <= m_n) begin
        k  = age - 1;
        ea = 9'(m_addr + 9'(k));
        chk("acc_mem_we", o_mem_we, m_we);
        chk("acc_mem_addr", o_mem_addr, ea);
        chk("acc_rsp_valid", o_rsp_valid, 0);
        if (m_we) begin
          chk("acc_mem_wdata", o_mem_wdata, m_wdata[8*k +: 8]);
          ref_mem[ea] = m_wdata[8*k +: 8];
        end
      end else begin
        chk("rsp_valid", o_rsp_valid, 1);
        chk("rsp_rdata", o_rsp_rdata, m_rdata);
        chk("rsp_err", o_rsp_err, m_err);
        chk("rsp_mem_we", o_mem_we, 0);
        if (rsp_ready && !rst) begin
          busy = 1'b0;
          hs_q.push_back(cyc);
        end
      end
    end
    if (rst) begin
      busy = 1'b0;
      model_ready = 1'b1;
    end
  end

  // Present a request and return just after the edge that accepts it.
  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [8:0] a, input logic [31:0] wd);
    int w = 0;
    req_valid = 1'b1; req_we = we; req_size = sz; req_uns = uns; req_addr = a; req_wdata = wd;
    do begin
      @(negedge clk);
      w++;
    end while (o_req_ready !== 1'b1 && w < 20);
    if (o_req_ready !== 1'b1) chk("accept_timeout", o_req_ready, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
    req_addr = 9'($urandom); req_wdata = $urandom;
  endtask

  // Wait for the response, then hold off i_rsp_ready for 'stall' cycles.
  task automatic get_rsp(input int stall, output logic [31:0] rd, output logic er, output int lat);
    rsp_ready = (stall == 0);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (o_rsp_valid !== 1'b1 && lat < 20);
    if (o_rsp_valid !== 1'b1) chk("rsp_timeout", o_rsp_valid, 1);
    rd = o_rsp_rdata;
    er = o_rsp_err;
    if (stall > 0) begin
      repeat (stall) @(posedge clk);
      #1 rsp_ready = 1'b1;
    end
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat, p, a0, h0, idx;
    logic        b_we [3];
    logic [1:0]  b_sz [3];
    logic [8:0]  b_ad [3];
    logic [31:0] b_wd [3];

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_req_ready", o_req_ready, 1);
    chk("reset_rsp_valid", o_rsp_valid, 0);
    chk("reset_rsp_err", o_rsp_err, 0);
    chk("reset_rsp_rdata", o_rsp_rdata, 0);
    chk("reset_mem_we", o_mem_we, 0);
    chk("reset_mem_addr", o_mem_addr, 0);
    chk("reset_mem_wdata", o_mem_wdata, 0);
    @(posedge clk); #1;

    // Word store, four byte writes.
    p = we_pulses;
    issue(1'b1, 2'd2, 1'b0, 9'h010, 32'hDEAD_BEEF);
    get_rsp(0, rd, er, lat);
    chk("st_word_latency", lat, 5);
    chk("st_word_err", er, 0);
    chk("st_word_rdata", rd, 0);
    chk("st_word_we_pulses", we_pulses - p, 4);
    chk("st_word_mem10", mem[9'h010], 32'hEF);
    chk("st_word_mem11", mem[9'h011], 32'hBE);
    chk("st_word_mem12", mem[9'h012], 32'hAD);
    chk("st_word_mem13", mem[9'h013], 32'hDE);

    // Loads of the stored word.
    issue(1'b0, 2'd0, 1'b0, 9'h013, 32'd0); get_rsp(0, rd, er, lat);
    chk("ld_sbyte", rd, 32'hFFFF_FFDE);
    chk("ld_sbyte_latency", lat, 2);
    issue(1'b0, 2'd1, 1'b1, 9'h012, 32'd0); get_rsp(1, rd, er, lat);
    chk("ld_uhalf", rd, 32'h0000_DEAD);
    issue(1'b0, 2'd1, 1'b0, 9'h010, 32'd0); get_rsp(0, rd, er, lat);
    chk("ld_shalf", rd, 32'hFFFF_BEEF);
    issue(1'b0, 2'd2, 1'b1, 9'h010, 32'd0); get_rsp(0, rd, er, lat);
    chk("ld_word", rd, 32'hDEAD_BEEF);

    // Error requests: one-cycle response, no BRAM traffic.
    p = we_pulses;
    issue(1'b1, 2'd2, 1'b0, 9'h011, 32'h1234_5678); get_rsp(0, rd, er, lat);
    chk("err_mis_latency", lat, 1);
    chk("err_mis_err", er, 1);
    chk("err_mis_rdata", rd, 0);
    issue(1'b0, 2'd3, 1'b0, 9'h000, 32'd0); get_rsp(0, rd, er, lat);
    chk("err_ill_latency", lat, 1);
    chk("err_ill_err", er, 1);
    chk("err_ill_rdata", rd, 0);
    chk("err_no_write", we_pulses - p, 0);

    // Backpressure on a byte load.
    h0 = hs_q.size();
    issue(1'b0, 2'd0, 1'b0, 9'h011, 32'd0); get_rsp(3, rd, er, lat);
    chk("bp_rdata", rd, 32'hFFFF_FFBE);
    chk("bp_hs_count", hs_q.size() - h0, 1);
    if (hs_q.size() > h0) chk("bp_hold_cycles", hs_q[h0] - acc_q[acc_q.size()-1], 5);

    // Reset while the second byte of a word store is on the bus.
    issue(1'b1, 2'd2, 1'b0, 9'h020, 32'h1122_3344); get_rsp(0, rd, er, lat);
    issue(1'b1, 2'd2, 1'b0, 9'h020, 32'hAABB_CCDD);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_req_ready", o_req_ready, 1);
    chk("rst_mid_rsp_valid", o_rsp_valid, 0);
    chk("rst_mid_mem_we", o_mem_we, 0);
    @(posedge clk); #1;
    issue(1'b0, 2'd2, 1'b0, 9'h020, 32'd0); get_rsp(0, rd, er, lat);
    chk("rst_mid_partial", rd, 32'h1122_CCDD);

    // Back-to-back with request valid held high.
    b_we[0] = 1'b0; b_sz[0] = 2'd0; b_ad[0] = 9'h013; b_wd[0] = 32'd0;
    b_we[1] = 1'b1; b_sz[1] = 2'd1; b_ad[1] = 9'h030; b_wd[1] = 32'h0000_5A5A;
    b_we[2] = 1'b0; b_sz[2] = 2'd2; b_ad[2] = 9'h010; b_wd[2] = 32'd0;
    a0 = acc_q.size(); h0 = hs_q.size(); idx = 0;
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_we = b_we[0]; req_size = b_sz[0]; req_uns = 1'b0;
    req_addr = b_ad[0]; req_wdata = b_wd[0];
    for (int c = 0; c < 100 && idx < 3; c++) begin
      @(negedge clk);
      if (o_req_ready) begin
        @(posedge clk);
        #1;
        idx++;
        if (idx < 3) begin
          req_we = b_we[idx]; req_size = b_sz[idx]; req_addr = b_ad[idx]; req_wdata = b_wd[idx];
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    repeat (12) @(posedge clk);
    #1 rsp_ready = 1'b0;
    chk("b2b_accepts", acc_q.size() - a0, 3);
    if (acc_q.size() >= a0 + 3 && hs_q.size() >= h0 + 2) begin
      chk("b2b_gap1", acc_q[a0+1] - hs_q[h0], 1);
      chk("b2b_gap2", acc_q[a0+2] - hs_q[h0+1], 1);
    end
    chk("b2b_half_mem", {mem[9'h031], mem[9'h030]}, 32'h5A5A);

    // Random traffic against the model.
    for (int t = 0; t < 120; t++) begin
      logic        we, uns, e;
      logic [1:0]  sz;
      logic [8:0]  a;
      we  = 1'($urandom);
      uns = 1'($urandom);
      sz  = 2'($urandom_range(0, 3));
      a   = 9'($urandom_range(0, 511));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      e = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
      issue(we, sz, uns, a, $urandom);
      get_rsp($urandom_range(0, 2), rd, er, lat);
      chk("rand_latency", lat, e ? 1 : (1 << sz) + 1);
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
